// File: rtl/dram_pkg.sv
// Shared types and helpers for the dispatch RAM loader.
// Words and addresses use 0 = MSB bit numbering to match the IR board prints.
package dram_pkg;

  localparam int DRAM_SIZE  = 512;
  localparam int DRAM_WIDTH = 15;
  localparam int ADR_W      = 9;

  localparam int A_FIRST     = 0;
  localparam int A_LAST      = 2;
  localparam int B_FIRST     = 3;
  localparam int B_LAST      = 5;
  localparam int PAR         = 6;
  localparam int J1_4_FIRST  = 7;
  localparam int J1_4_LAST   = 10;
  localparam int J7_10_FIRST = 11;
  localparam int J7_10_LAST  = 14;
  localparam int PAR_BIT     = PAR;

  typedef logic [0:DRAM_WIDTH-1] dram_word_t;
  typedef logic [0:ADR_W-1]      dram_adr_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_WAIT,
    FILL
  } dram_ldr_state_t;

  // 1 when the word already has odd parity
  function automatic logic dram_odd_par(input dram_word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/dram_loader.sv
// Port sequencer/arbiter in front of the 512x15 dispatch RAM.
// Optional parity generate/check: define DRAM_PARITY_GEN_EN.
module dram_loader
  import dram_pkg::*;
#(
  parameter dram_word_t FILL_WORD = 15'o0
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       lookup_req,
  input  dram_adr_t  lookup_adr,
  output dram_word_t lookup_data,
  output logic       lookup_valid,
  input  logic       diag_adr_ld,
  input  logic       diag_wr,
  input  logic       diag_rd,
  input  logic       diag_fill,
  input  dram_word_t diag_data,
  output dram_word_t diag_rd_data,
  output logic       diag_rd_valid,
  output logic       busy,
  output dram_adr_t  diag_adr,
  output logic       par_err,
  output dram_adr_t  ram_addr,
  output dram_word_t ram_din,
  output logic       ram_we,
  input  dram_word_t ram_dout
);

  localparam dram_adr_t ADR_LAST = dram_adr_t'(DRAM_SIZE - 1);
  localparam dram_adr_t ADR_ONE  = dram_adr_t'(1);

  dram_ldr_state_t state_q, state_d;
  dram_adr_t       adr_q, adr_d;
  dram_word_t      wdata_q, wdata_d;
  logic            lookup_valid_q, lookup_valid_d;
  logic            par_err_q, par_err_d;
  logic            par_clr;
  dram_word_t      din_raw;

`ifdef DRAM_PARITY_GEN_EN
  function automatic dram_word_t par_fix(input dram_word_t w);
    dram_word_t r;
    r = w;
    r[PAR_BIT] = 1'b0;
    r[PAR_BIT] = ~dram_odd_par(r);
    return r;
  endfunction
`endif

  // State, address, write data and status registers
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q        <= IDLE;
      adr_q          <= '0;
      wdata_q        <= '0;
      lookup_valid_q <= 1'b0;
      par_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      adr_q          <= adr_d;
      wdata_q        <= wdata_d;
      lookup_valid_q <= lookup_valid_d;
      par_err_q      <= par_err_d;
    end
  end

  // Next state; RAM-using states hold while a lookup owns the port
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    par_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (diag_fill) begin
          state_d = FILL;
          adr_d   = '0;
          par_clr = 1'b1;
        end else if (diag_wr) begin
          state_d = WRITE;
          wdata_d = diag_data;
        end else if (diag_rd) begin
          state_d = READ;
        end else if (diag_adr_ld) begin
          adr_d = diag_data[6:14];
        end
      end
      WRITE: begin
        if (!lookup_req) begin
          adr_d   = adr_q + ADR_ONE;
          state_d = IDLE;
        end
      end
      READ: begin
        if (!lookup_req) state_d = READ_WAIT;
      end
      READ_WAIT: begin
        adr_d   = adr_q + ADR_ONE;
        state_d = IDLE;
      end
      FILL: begin
        if (!lookup_req) begin
          if (adr_q == ADR_LAST) begin
            adr_d   = '0;
            state_d = IDLE;
          end else begin
            adr_d = adr_q + ADR_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lookup result tracking and sticky parity error
  always_comb begin
    lookup_valid_d = lookup_req;
`ifdef DRAM_PARITY_GEN_EN
    if (par_clr)
      par_err_d = 1'b0;
    else if (lookup_valid_q && !dram_odd_par(ram_dout))
      par_err_d = 1'b1;
    else
      par_err_d = par_err_q;
`else
    par_err_d = 1'b0;
`endif
  end

  // Port mux and status outputs; lookup always wins the port
  always_comb begin
    busy          = (state_q != IDLE);
    diag_rd_valid = (state_q == READ_WAIT);
    diag_rd_data  = diag_rd_valid ? ram_dout : '0;
    lookup_valid  = lookup_valid_q;
    lookup_data   = lookup_valid_q ? ram_dout : '0;
    diag_adr      = adr_q;
    par_err       = par_err_q;
    ram_addr      = lookup_req ? lookup_adr : adr_q;
    ram_we        = !RESET && !lookup_req &&
                    (state_q == WRITE || state_q == FILL);
    din_raw       = (state_q == FILL) ? FILL_WORD : wdata_q;
`ifdef DRAM_PARITY_GEN_EN
    ram_din       = ram_we ? par_fix(din_raw) : '0;
`else
    ram_din       = ram_we ? din_raw : '0;
`endif
  end

endmodule

// File: tb/tb_dram_loader.sv
// Directed bench for dram_loader with a registered-read RAM model.
// Parity expectations follow DRAM_PARITY_GEN_EN when defined.
module tb_dram_loader;

  localparam logic [0:14] FW = 15'o12345;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        lookup_req = 1'b0;
  logic [0:8]  lookup_adr = '0;
  logic [0:14] lookup_data;
  logic        lookup_valid;
  logic        diag_adr_ld = 1'b0;
  logic        diag_wr = 1'b0;
  logic        diag_rd = 1'b0;
  logic        diag_fill = 1'b0;
  logic [0:14] diag_data = '0;
  logic [0:14] diag_rd_data;
  logic        diag_rd_valid;
  logic        busy;
  logic [0:8]  diag_adr;
  logic        par_err;
  logic [0:8]  ram_addr;
  logic [0:14] ram_din;
  logic        ram_we;
  logic [0:14] ram_dout;

  logic        pre_en = 1'b0;
  logic [0:8]  pre_adr = '0;
  logic [0:14] pre_val = '0;
  logic [0:14] mem [0:511];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) mem[pre_adr] <= pre_val;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  dram_loader #(.FILL_WORD(FW)) dut (
    .clk(clk), .RESET(RESET),
    .lookup_req(lookup_req), .lookup_adr(lookup_adr),
    .lookup_data(lookup_data), .lookup_valid(lookup_valid),
    .diag_adr_ld(diag_adr_ld), .diag_wr(diag_wr),
    .diag_rd(diag_rd), .diag_fill(diag_fill),
    .diag_data(diag_data), .diag_rd_data(diag_rd_data),
    .diag_rd_valid(diag_rd_valid), .busy(busy),
    .diag_adr(diag_adr), .par_err(par_err),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout)
  );

  function automatic logic [0:14] exp_word(input logic [0:14] w);
    logic [0:14] r;
    r = w;
`ifdef DRAM_PARITY_GEN_EN
    r[6] = 1'b0;
    if (($countones(r) % 2) == 0) r[6] = 1'b1;
`endif
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_adr(input logic [0:8] a);
    diag_data = {6'b0, a};
    diag_adr_ld = 1'b1;
    cyc();
    diag_adr_ld = 1'b0;
  endtask

  task automatic rd_word(input logic [0:8] a, output logic [0:14] w,
                         output int lat, output bit ok);
    set_adr(a);
    diag_rd = 1'b1;
    cyc();
    diag_rd = 1'b0;
    lat = 0;
    while (!diag_rd_valid && lat < 10) begin
      cyc();
      lat++;
    end
    ok = diag_rd_valid;
    w = diag_rd_data;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    cyc(); cyc();
    RESET = 1'b0;
    #1;
    total++;
    if ({busy, lookup_valid, diag_rd_valid, ram_we, par_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {busy, lookup_valid, diag_rd_valid, ram_we, par_err});
    end
    total++;
    if (diag_adr !== 9'o0 || lookup_data !== 15'o0 ||
        diag_rd_data !== 15'o0 || ram_din !== 15'o0) begin
      bad++;
      $display("FAIL reset_data adr=%o lk=%o rd=%o din=%o want 0",
               diag_adr, lookup_data, diag_rd_data, ram_din);
    end
  endtask

  task automatic test_write();
    set_adr(9'o777);
    total++;
    if (diag_adr !== 9'o777 || busy !== 1'b0) begin
      bad++;
      $display("FAIL adr_ld adr=%o busy=%b want 777/0", diag_adr, busy);
    end
    diag_data = 15'o00017;
    diag_wr = 1'b1;
    cyc();
    diag_wr = 1'b0;
    #1;
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 9'o777 ||
        ram_din !== exp_word(15'o17) || busy !== 1'b1) begin
      bad++;
      $display("FAIL wr_port we=%b a=%o d=%o busy=%b want 1/777/%o/1",
               ram_we, ram_addr, ram_din, busy, exp_word(15'o17));
    end
    cyc();
    total++;
    if (busy !== 1'b0 || diag_adr !== 9'o0) begin
      bad++;
      $display("FAIL wr_wrap busy=%b adr=%o want 0/0", busy, diag_adr);
    end
    diag_data = 15'o00022;
    diag_wr = 1'b1;
    cyc();
    diag_wr = 1'b0;
    cyc();
    total++;
    if (diag_adr !== 9'o1 || mem[9'o777] !== exp_word(15'o17) ||
        mem[0] !== exp_word(15'o22)) begin
      bad++;
      $display("FAIL wr_incr adr=%o m777=%o m0=%o want 1/%o/%o", diag_adr,
               mem[9'o777], mem[0], exp_word(15'o17), exp_word(15'o22));
    end
  endtask

  task automatic test_lookup_priority();
    logic [0:8]  la;
    logic [0:14] pexp;
    set_adr(9'o5);
    diag_data = 15'o00055;
    diag_wr = 1'b1;
    cyc();
    diag_wr = 1'b0;
    pexp = '0;
    for (int i = 0; i < 4; i++) begin
      la = (i % 2 == 1) ? 9'o0 : 9'o777;
      lookup_req = 1'b1;
      lookup_adr = la;
      #1;
      total++;
      if (ram_we !== 1'b0 || ram_addr !== la || busy !== 1'b1) begin
        bad++;
        $display("FAIL lk_stall%0d we=%b a=%o busy=%b want 0/%o/1",
                 i, ram_we, ram_addr, busy, la);
      end
      if (i > 0) begin
        total++;
        if (lookup_valid !== 1'b1 || lookup_data !== pexp) begin
          bad++;
          $display("FAIL lk_data%0d v=%b d=%o want 1/%o",
                   i, lookup_valid, lookup_data, pexp);
        end
      end
      pexp = (la == 9'o0) ? exp_word(15'o22) : exp_word(15'o17);
      cyc();
    end
    lookup_req = 1'b0;
    #1;
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 9'o5 || ram_din !== exp_word(15'o55)
        || lookup_valid !== 1'b1 || lookup_data !== pexp) begin
      bad++;
      $display("FAIL lk_wr5 we=%b a=%o d=%o v=%b ld=%o want 1/5/%o/1/%o",
               ram_we, ram_addr, ram_din, lookup_valid, lookup_data,
               exp_word(15'o55), pexp);
    end
    cyc();
    total++;
    if (lookup_valid !== 1'b0 || busy !== 1'b0 ||
        mem[5] !== exp_word(15'o55) || diag_adr !== 9'o6) begin
      bad++;
      $display("FAIL lk_done v=%b busy=%b m5=%o adr=%o want 0/0/%o/6",
               lookup_valid, busy, mem[5], diag_adr, exp_word(15'o55));
    end
  endtask

  task automatic test_strobes();
    int rv;
    rv = 0;
    set_adr(9'o10);
    diag_data = 15'o00033;
    diag_wr = 1'b1;
    diag_rd = 1'b1;
    cyc();
    diag_wr = 1'b0;
    #1;
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 9'o10) begin
      bad++;
      $display("FAIL multi_wr we=%b a=%o want 1/10", ram_we, ram_addr);
    end
    cyc();
    diag_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (diag_rd_valid) rv++;
      cyc();
    end
    total++;
    if (rv !== 0 || busy !== 1'b0 || diag_adr !== 9'o11 ||
        mem[8] !== exp_word(15'o33)) begin
      bad++;
      $display("FAIL multi_drop rv=%0d busy=%b adr=%o m10=%o want 0/0/11/%o",
               rv, busy, diag_adr, mem[8], exp_word(15'o33));
    end
  endtask

  task automatic test_fill_read();
    int n;
    int lat;
    bit ok;
    logic [0:14] w;
    diag_fill = 1'b1;
    cyc();
    diag_fill = 1'b0;
    n = 0;
    while (busy && n < 600) begin
      n++;
      cyc();
    end
    total++;
    if (n !== 512 || diag_adr !== 9'o0) begin
      bad++;
      $display("FAIL fill_len busy_cycles=%0d adr=%o want 512/0", n, diag_adr);
    end
    rd_word(9'o0, w, lat, ok);
    total++;
    if (!ok || lat !== 1 || w !== exp_word(FW)) begin
      bad++;
      $display("FAIL fill_rd0 ok=%b lat=%0d d=%o want 1/1/%o",
               ok, lat, w, exp_word(FW));
    end
    cyc();
    total++;
    if (diag_adr !== 9'o1) begin
      bad++;
      $display("FAIL rd_incr adr=%o want 1", diag_adr);
    end
    rd_word(9'o777, w, lat, ok);
    total++;
    if (!ok || w !== exp_word(FW)) begin
      bad++;
      $display("FAIL fill_rd777 ok=%b d=%o want 1/%o", ok, w, exp_word(FW));
    end
    cyc();
  endtask

  task automatic test_reset_mid_fill();
    int nbad;
    for (int i = 0; i < 106; i++) begin
      pre_en = 1'b1;
      pre_adr = 9'(i);
      pre_val = 15'o7;
      cyc();
    end
    pre_en = 1'b0;
    diag_fill = 1'b1;
    cyc();
    diag_fill = 1'b0;
    repeat (100) cyc();
    total++;
    if (diag_adr !== 9'd100 || busy !== 1'b1) begin
      bad++;
      $display("FAIL fill_mid adr=%0d busy=%b want 100/1", diag_adr, busy);
    end
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || diag_adr !== 9'o0 || ram_we !== 1'b0) begin
      bad++;
      $display("FAIL rst_fill busy=%b adr=%o we=%b want 0/0/0",
               busy, diag_adr, ram_we);
    end
    nbad = 0;
    for (int i = 0; i < 100; i++)
      if (mem[i] !== exp_word(FW)) nbad++;
    total++;
    if (nbad !== 0 || mem[101] !== 15'o7) begin
      bad++;
      $display("FAIL rst_words bad_words=%0d m101=%o want 0/7",
               nbad, mem[101]);
    end
  endtask

  task automatic test_parity();
    logic exp_pe;
    int n;
`ifdef DRAM_PARITY_GEN_EN
    exp_pe = 1'b1;
`else
    exp_pe = 1'b0;
`endif
    pre_en = 1'b1;
    pre_adr = 9'o3;
    pre_val = 15'o3;
    cyc();
    pre_en = 1'b0;
    lookup_req = 1'b1;
    lookup_adr = 9'o3;
    cyc();
    lookup_req = 1'b0;
    #1;
    total++;
    if (lookup_valid !== 1'b1 || lookup_data !== 15'o3) begin
      bad++;
      $display("FAIL par_lk v=%b d=%o want 1/3", lookup_valid, lookup_data);
    end
    cyc();
    total++;
    if (par_err !== exp_pe) begin
      bad++;
      $display("FAIL par_set got=%b want=%b", par_err, exp_pe);
    end
    repeat (3) cyc();
    total++;
    if (par_err !== exp_pe) begin
      bad++;
      $display("FAIL par_sticky got=%b want=%b", par_err, exp_pe);
    end
    diag_fill = 1'b1;
    cyc();
    diag_fill = 1'b0;
    total++;
    if (par_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL par_clr pe=%b busy=%b want 0/1", par_err, busy);
    end
    n = 0;
    while (busy && n < 600) begin
      n++;
      cyc();
    end
    total++;
    if (busy !== 1'b0 || mem[3] !== exp_word(FW)) begin
      bad++;
      $display("FAIL par_fill busy=%b m3=%o want 0/%o",
               busy, mem[3], exp_word(FW));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_lookup_priority();
    test_strobes();
    test_fill_read();
    test_reset_mid_fill();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
